// File: rtl/cond_branch_unit_pkg.sv
// ---------------------------------------------------------------------------
// cond_branch_unit_pkg
//   Shared definitions for the conditional branch unit:
//     - SPARC Bicc condition field encodings (COND_BN .. COND_BVC)
//     - flag bit positions inside a {N,Z,V,C} condition-code nibble
//     - 2-bit branch history counter states and their update function
// ---------------------------------------------------------------------------
package cond_branch_unit_pkg;

    // Bicc condition field encodings
    localparam logic [3:0] COND_BN   = 4'h0;  // never
    localparam logic [3:0] COND_BE   = 4'h1;  // Z
    localparam logic [3:0] COND_BLE  = 4'h2;  // Z | (N ^ V)
    localparam logic [3:0] COND_BL   = 4'h3;  // N ^ V
    localparam logic [3:0] COND_BLEU = 4'h4;  // C | Z
    localparam logic [3:0] COND_BCS  = 4'h5;  // C
    localparam logic [3:0] COND_BNEG = 4'h6;  // N
    localparam logic [3:0] COND_BVS  = 4'h7;  // V
    localparam logic [3:0] COND_BA   = 4'h8;  // always
    localparam logic [3:0] COND_BNE  = 4'h9;
    localparam logic [3:0] COND_BG   = 4'hA;
    localparam logic [3:0] COND_BGE  = 4'hB;
    localparam logic [3:0] COND_BGU  = 4'hC;
    localparam logic [3:0] COND_BCC  = 4'hD;
    localparam logic [3:0] COND_BPOS = 4'hE;
    localparam logic [3:0] COND_BVC  = 4'hF;

    // Flag positions within {N,Z,V,C}
    localparam int F_N = 3;
    localparam int F_Z = 2;
    localparam int F_V = 1;
    localparam int F_C = 0;

    // 2-bit saturating direction counter; MSB is the predicted direction
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    // Saturating counter step toward the resolved direction
    function automatic bht_state_e bht_next(input bht_state_e s, input logic taken);
        bht_state_e r;
        case (s)
            SNT:     r = taken ? WNT : SNT;
            WNT:     r = taken ? WT  : SNT;
            WT:      r = taken ? ST  : WNT;
            ST:      r = taken ? ST  : WT;
            default: r = WNT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cond_branch_unit_cond_eval.sv
// ---------------------------------------------------------------------------
// cond_branch_unit_cond_eval
//   Pure combinational Bicc condition evaluator.
//   Ports:
//     flags  in  4  condition codes {N,Z,V,C}
//     cond   in  4  Bicc cond field
//     taken  out 1  condition satisfied
// ---------------------------------------------------------------------------
module cond_branch_unit_cond_eval
    import cond_branch_unit_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       taken
);

    logic n_f, z_f, v_f, c_f;

    assign n_f = flags[F_N];
    assign z_f = flags[F_Z];
    assign v_f = flags[F_V];
    assign c_f = flags[F_C];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_BN:   taken = 1'b0;
            COND_BE:   taken = z_f;
            COND_BLE:  taken = z_f | (n_f ^ v_f);
            COND_BL:   taken = n_f ^ v_f;
            COND_BLEU: taken = c_f | z_f;
            COND_BCS:  taken = c_f;
            COND_BNEG: taken = n_f;
            COND_BVS:  taken = v_f;
            COND_BA:   taken = 1'b1;
            COND_BNE:  taken = ~z_f;
            COND_BG:   taken = ~(z_f | (n_f ^ v_f));
            COND_BGE:  taken = ~(n_f ^ v_f);
            COND_BGU:  taken = ~(c_f | z_f);
            COND_BCC:  taken = ~c_f;
            COND_BPOS: taken = ~n_f;
            COND_BVC:  taken = ~v_f;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_branch_unit.sv
// ---------------------------------------------------------------------------
// cond_branch_unit
//   Condition-code file, Bicc evaluation with same-cycle CC forwarding,
//   annul-bit handling, 2-bit counter branch prediction and a one-stage
//   resolution register that reports mispredicts to fetch/flush logic.
//   Ports:
//     clk, rst_n             clock (rising edge), async active-low reset
//     cc_we/cc_wsel/cc_in    EX-stage condition-code write
//     id_branch_instr, id_pc, id_cond, id_annul, id_cc_sel
//                            branch presented in ID this cycle
//     stall                  hold resolution register, no table update
//     flush                  drop the pending resolution
//     pred_taken             combinational prediction for the ID branch
//     res_valid/res_taken/res_annul/res_mispredict/res_pc
//                            registered resolution of the previous branch
//     miss_count             saturating mispredict counter
// ---------------------------------------------------------------------------
module cond_branch_unit
    import cond_branch_unit_pkg::*;
#(
    parameter  int NUM_CC     = 2,
    parameter  int BHT_DEPTH  = 16,
    parameter  int PC_W       = 32,
    parameter  int MISS_CNT_W = 16,
    localparam int CC_SEL_W   = (NUM_CC > 1) ? $clog2(NUM_CC) : 1,
    localparam int IDX_W      = $clog2(BHT_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cc_we,
    input  logic [CC_SEL_W-1:0]   cc_wsel,
    input  logic [3:0]            cc_in,
    input  logic                  id_branch_instr,
    input  logic [PC_W-1:0]       id_pc,
    input  logic [3:0]            id_cond,
    input  logic                  id_annul,
    input  logic [CC_SEL_W-1:0]   id_cc_sel,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  pred_taken,
    output logic                  res_valid,
    output logic                  res_taken,
    output logic                  res_annul,
    output logic                  res_mispredict,
    output logic [PC_W-1:0]       res_pc,
    output logic [MISS_CNT_W-1:0] miss_count
);

    // ------------------------------------------------------------------
    // Condition-code registers
    // ------------------------------------------------------------------
    logic [3:0]        cc_q [NUM_CC];
    logic [3:0]        cc_d [NUM_CC];
    logic [NUM_CC-1:0] cc_hit;

    // One-hot write decode; a select with no matching set hits nothing,
    // so out-of-range writes are dropped naturally.
    for (genvar gi = 0; gi < NUM_CC; gi++) begin : g_cc_hit
        assign cc_hit[gi] = cc_we && (cc_wsel == CC_SEL_W'(gi));
    end

    always_comb begin
        for (int i = 0; i < NUM_CC; i++) begin
            cc_d[i] = cc_hit[i] ? cc_in : cc_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CC; i++) begin
                cc_q[i] <= 4'b0000;
            end
        end else begin
            cc_q <= cc_d;
        end
    end

    // ------------------------------------------------------------------
    // Flag selection with forwarding of the write happening this cycle
    // ------------------------------------------------------------------
    logic [3:0] flags_reg;
    logic [3:0] flags_fwd;

    always_comb begin
        flags_reg = 4'b0000;
        for (int i = 0; i < NUM_CC; i++) begin
            if (id_cc_sel == CC_SEL_W'(i)) begin
                flags_reg = cc_q[i];
            end
        end
        flags_fwd = (cc_we && (cc_wsel == id_cc_sel)) ? cc_in : flags_reg;
    end

    logic cond_true;

    cond_branch_unit_cond_eval u_cond_eval (
        .flags (flags_fwd),
        .cond  (id_cond),
        .taken (cond_true)
    );

    // ------------------------------------------------------------------
    // ID-stage outcome, annul and prediction
    // ------------------------------------------------------------------
    logic             id_is_ba;
    logic             id_is_bn;
    logic             id_taken;
    logic             id_annul_eff;
    logic [IDX_W-1:0] id_idx;
    bht_state_e       bht_q [BHT_DEPTH];
    bht_state_e       bht_d [BHT_DEPTH];
    bht_state_e       id_ctr;

    assign id_is_ba = (id_cond == COND_BA);
    assign id_is_bn = (id_cond == COND_BN);
    assign id_taken = id_branch_instr && cond_true;
    assign id_idx   = id_pc[IDX_W+1:2];

    // BA,a annuls even though it is taken; BN,a annuls like any untaken
    // annulling branch.
    assign id_annul_eff = id_branch_instr && id_annul &&
                          (id_is_ba || id_is_bn || !id_taken);

    always_comb begin
        id_ctr     = bht_q[id_idx];
        pred_taken = id_ctr[1];
        if (id_is_ba) begin
            pred_taken = 1'b1;
        end else if (id_is_bn) begin
            pred_taken = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Resolution register
    // ------------------------------------------------------------------
    logic             valid_q, valid_d;
    logic             taken_q, taken_d;
    logic             annul_q, annul_d;
    logic             pred_q,  pred_d;
    logic             learn_q, learn_d;   // branch is allowed to train the table
    logic [PC_W-1:0]  pc_q,    pc_d;
    logic [IDX_W-1:0] idx_q,   idx_d;

    always_comb begin
        valid_d = valid_q;
        taken_d = taken_q;
        annul_d = annul_q;
        pred_d  = pred_q;
        learn_d = learn_q;
        pc_d    = pc_q;
        idx_d   = idx_q;
        if (flush) begin
            valid_d = 1'b0;
            taken_d = 1'b0;
            annul_d = 1'b0;
            pred_d  = 1'b0;
            learn_d = 1'b0;
            pc_d    = '0;
            idx_d   = '0;
        end else if (!stall) begin
            // A bubble in ID leaves an all-zero resolution behind
            valid_d = id_branch_instr;
            taken_d = id_taken;
            annul_d = id_annul_eff;
            pred_d  = id_branch_instr && pred_taken;
            learn_d = id_branch_instr && !id_is_ba && !id_is_bn;
            pc_d    = id_branch_instr ? id_pc  : '0;
            idx_d   = id_branch_instr ? id_idx : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            taken_q <= 1'b0;
            annul_q <= 1'b0;
            pred_q  <= 1'b0;
            learn_q <= 1'b0;
            pc_q    <= '0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            taken_q <= taken_d;
            annul_q <= annul_d;
            pred_q  <= pred_d;
            learn_q <= learn_d;
            pc_q    <= pc_d;
            idx_q   <= idx_d;
        end
    end

    assign res_valid      = valid_q;
    assign res_taken      = taken_q;
    assign res_annul      = annul_q;
    assign res_pc         = pc_q;
    assign res_mispredict = valid_q && (taken_q != pred_q);

    // A resolution retires on the edge where it leaves the register
    // normally; stalled or flushed resolutions retire nothing.
    logic retire;
    assign retire = valid_q && !stall && !flush;

    // ------------------------------------------------------------------
    // Branch history table
    // ------------------------------------------------------------------
    logic [BHT_DEPTH-1:0] bht_hit;

    for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht_hit
        assign bht_hit[gi] = retire && learn_q && (idx_q == IDX_W'(gi));
    end

    // ID reads bht_q directly, so a same-cycle update is not visible until
    // the following cycle.
    always_comb begin
        for (int i = 0; i < BHT_DEPTH; i++) begin
            bht_d[i] = bht_hit[i] ? bht_next(bht_q[i], taken_q) : bht_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= WNT;
            end
        end else begin
            bht_q <= bht_d;
        end
    end

    // ------------------------------------------------------------------
    // Saturating mispredict counter
    // ------------------------------------------------------------------
    logic [MISS_CNT_W-1:0] miss_q, miss_d;

    always_comb begin
        miss_d = miss_q;
        if (retire && res_mispredict && (miss_q != {MISS_CNT_W{1'b1}})) begin
            miss_d = miss_q + MISS_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_q <= '0;
        end else begin
            miss_q <= miss_d;
        end
    end

    assign miss_count = miss_q;

endmodule

// File: tb/tb_cond_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_cond_branch_unit
//   Self-checking bench: directed scenarios with literal expectations plus
//   a randomized run, all compared every cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_cond_branch_unit;

    localparam int NUM_CC     = 2;
    localparam int BHT_DEPTH  = 16;
    localparam int PC_W       = 32;
    localparam int MISS_CNT_W = 6;
    localparam int CC_SEL_W   = 1;
    localparam int MISS_MAX   = (1 << MISS_CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  cc_we;
    logic [CC_SEL_W-1:0]   cc_wsel;
    logic [3:0]            cc_in;
    logic                  id_branch_instr;
    logic [PC_W-1:0]       id_pc;
    logic [3:0]            id_cond;
    logic                  id_annul;
    logic [CC_SEL_W-1:0]   id_cc_sel;
    logic                  stall;
    logic                  flush;
    logic                  pred_taken;
    logic                  res_valid;
    logic                  res_taken;
    logic                  res_annul;
    logic                  res_mispredict;
    logic [PC_W-1:0]       res_pc;
    logic [MISS_CNT_W-1:0] miss_count;

    cond_branch_unit #(
        .NUM_CC     (NUM_CC),
        .BHT_DEPTH  (BHT_DEPTH),
        .PC_W       (PC_W),
        .MISS_CNT_W (MISS_CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cc_we           (cc_we),
        .cc_wsel         (cc_wsel),
        .cc_in           (cc_in),
        .id_branch_instr (id_branch_instr),
        .id_pc           (id_pc),
        .id_cond         (id_cond),
        .id_annul        (id_annul),
        .id_cc_sel       (id_cc_sel),
        .stall           (stall),
        .flush           (flush),
        .pred_taken      (pred_taken),
        .res_valid       (res_valid),
        .res_taken       (res_taken),
        .res_annul       (res_annul),
        .res_mispredict  (res_mispredict),
        .res_pc          (res_pc),
        .miss_count      (miss_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [3:0]  m_cc  [NUM_CC];
    int          m_bht [BHT_DEPTH];
    bit          p_valid, p_taken, p_annul, p_pred;
    logic [31:0] p_pc;
    logic [3:0]  p_cond;
    int          m_miss;

    function automatic void model_reset();
        for (int i = 0; i < NUM_CC; i++) m_cc[i] = 4'b0000;
        for (int i = 0; i < BHT_DEPTH; i++) m_bht[i] = 1;
        p_valid = 0; p_taken = 0; p_annul = 0; p_pred = 0;
        p_pc = '0; p_cond = '0; m_miss = 0;
    endfunction

    // Lower 3 bits pick the base test; bit 3 complements it (so 1000 = !never)
    function automatic bit m_eval(input logic [3:0] f, input logic [3:0] c);
        bit n, z, v, cy, base;
        n = f[3]; z = f[2]; v = f[1]; cy = f[0];
        case (c[2:0])
            3'd0: base = 0;
            3'd1: base = z;
            3'd2: base = z | (n ^ v);
            3'd3: base = n ^ v;
            3'd4: base = cy | z;
            3'd5: base = cy;
            3'd6: base = n;
            default: base = v;
        endcase
        return c[3] ? !base : base;
    endfunction

    function automatic logic [3:0] m_flags();
        if (cc_we && cc_wsel == id_cc_sel) return cc_in;
        return m_cc[id_cc_sel];
    endfunction

    function automatic bit m_pred();
        int idx;
        idx = int'((id_pc >> 2) % BHT_DEPTH);
        if (id_cond == 4'd8) return 1;
        if (id_cond == 4'd0) return 0;
        return m_bht[idx] >= 2;
    endfunction

    function automatic bit m_taken();
        return id_branch_instr && m_eval(m_flags(), id_cond);
    endfunction

    function automatic bit m_annul(input bit tk);
        if (!id_branch_instr || !id_annul) return 0;
        if (id_cond == 4'd8 || id_cond == 4'd0) return 1;
        return !tk;
    endfunction

    // Advance one clock edge, updating the model with the held inputs
    task automatic tick();
        bit tk, an, pr;
        int pidx;
        @(posedge clk);
        if (rst_n) begin
            tk = m_taken();
            an = m_annul(tk);
            pr = id_branch_instr && m_pred();
            if (p_valid && !stall && !flush) begin
                pidx = int'((p_pc >> 2) % BHT_DEPTH);
                if (p_cond != 4'd0 && p_cond != 4'd8) begin
                    if (p_taken) m_bht[pidx] = (m_bht[pidx] < 3) ? m_bht[pidx] + 1 : 3;
                    else         m_bht[pidx] = (m_bht[pidx] > 0) ? m_bht[pidx] - 1 : 0;
                end
                if (p_taken != p_pred && m_miss < MISS_MAX) m_miss++;
            end
            if (cc_we) m_cc[cc_wsel] = cc_in;
            if (flush) begin
                p_valid = 0; p_taken = 0; p_annul = 0; p_pred = 0; p_pc = '0; p_cond = '0;
            end else if (!stall) begin
                p_valid = id_branch_instr;
                p_taken = tk;
                p_annul = an;
                p_pred  = pr;
                p_pc    = id_branch_instr ? id_pc : '0;
                p_cond  = id_branch_instr ? id_cond : '0;
            end
        end
        #1;
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pred_taken", 32'(pred_taken), 32'(m_pred()));
            chk("res_valid", 32'(res_valid), 32'(p_valid));
            chk("res_taken", 32'(res_taken), 32'(p_taken));
            chk("res_annul", 32'(res_annul), 32'(p_annul));
            chk("res_mispredict", 32'(res_mispredict), 32'(p_valid && (p_taken != p_pred)));
            chk("res_pc", res_pc, p_pc);
            chk("miss_count", 32'(miss_count), 32'(m_miss));
        end
    end

    task automatic idle();
        cc_we = 0; cc_wsel = '0; cc_in = '0;
        id_branch_instr = 0; id_pc = '0; id_cond = '0; id_annul = 0; id_cc_sel = '0;
        stall = 0; flush = 0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [3:0] c, input bit a, input bit sel);
        id_branch_instr = 1; id_pc = pc; id_cond = c; id_annul = a; id_cc_sel = sel;
    endtask

    task automatic write_cc(input bit sel, input logic [3:0] f);
        cc_we = 1; cc_wsel = sel; cc_in = f;
    endtask

    initial begin
        rst_n = 0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_res_valid", 32'(res_valid), 32'd0);
        chk("reset_res_pc", res_pc, 32'd0);
        chk("reset_miss", 32'(miss_count), 32'd0);
        rst_n = 1;
        chk_en = 1;
        tick();

        // BA,a at 0x40
        issue(32'h40, 4'h8, 1, 0); #1;
        chk("ba_pred", 32'(pred_taken), 32'd1);
        tick(); idle(); #1;
        chk("ba_valid", 32'(res_valid), 32'd1);
        chk("ba_taken", 32'(res_taken), 32'd1);
        chk("ba_annul", 32'(res_annul), 32'd1);
        chk("ba_misp", 32'(res_mispredict), 32'd0);
        tick();

        // BE with forwarded Z in the same cycle
        write_cc(0, 4'b0100); issue(32'h44, 4'h1, 0, 0); #1;
        chk("be_fwd_pred", 32'(pred_taken), 32'd0);
        tick(); idle(); #1;
        chk("be_fwd_taken", 32'(res_taken), 32'd1);
        chk("be_fwd_misp", 32'(res_mispredict), 32'd1);
        tick();
        chk("be_fwd_miss", 32'(miss_count), 32'd1);

        // BNE at 0x80 three times, Z=0: counter 01 -> 10 -> 11 -> 11
        write_cc(0, 4'b0000); tick(); idle();
        for (int k = 0; k < 3; k++) begin
            issue(32'h80, 4'h9, 0, 0); #1;
            chk("bne_pred", 32'(pred_taken), 32'(k != 0));
            tick(); idle(); #1;
            chk("bne_misp", 32'(res_mispredict), 32'(k == 0));
            tick();
        end
        chk("bne_miss", 32'(miss_count), 32'd2);

        // BL with N=V=0: not taken, annul follows the a-bit
        issue(32'h10C, 4'h3, 1, 0);
        tick(); idle(); #1;
        chk("bl_a1_taken", 32'(res_taken), 32'd0);
        chk("bl_a1_annul", 32'(res_annul), 32'd1);
        issue(32'h10C, 4'h3, 0, 0);
        tick(); idle(); #1;
        chk("bl_a0_annul", 32'(res_annul), 32'd0);
        tick();

        // Mispredicting BNE held by stall, then flushed
        issue(32'h48, 4'h9, 0, 0);
        tick(); idle(); stall = 1;
        tick(); tick();
        chk("stall_valid", 32'(res_valid), 32'd1);
        chk("stall_miss", 32'(miss_count), 32'd2);
        stall = 0; flush = 1;
        tick(); idle(); #1;
        chk("flush_valid", 32'(res_valid), 32'd0);
        chk("flush_miss", 32'(miss_count), 32'd2);
        issue(32'h48, 4'h9, 0, 0); #1;
        chk("flush_no_bht_upd", 32'(pred_taken), 32'd0);
        tick(); idle();
        tick();

        // Separate CC sets
        write_cc(1, 4'b1000); tick();
        write_cc(0, 4'b0000); tick(); idle();
        issue(32'h200, 4'h6, 0, 1);
        tick(); idle(); #1;
        chk("bneg_sel1", 32'(res_taken), 32'd1);
        issue(32'h200, 4'h6, 0, 0);
        tick(); idle(); #1;
        chk("bneg_sel0", 32'(res_taken), 32'd0);

        // Asynchronous reset mid-stream with a resolution pending
        issue(32'h84, 4'h8, 1, 0);
        tick(); idle();
        chk_en = 0;
        rst_n = 0; #1;
        chk("areset_valid", 32'(res_valid), 32'd0);
        chk("areset_taken", 32'(res_taken), 32'd0);
        chk("areset_annul", 32'(res_annul), 32'd0);
        chk("areset_pc", res_pc, 32'd0);
        chk("areset_miss", 32'(miss_count), 32'd0);
        model_reset();
        tick(); tick();
        rst_n = 1;
        issue(32'h80, 4'h9, 0, 0); #1;
        chk("areset_bht", 32'(pred_taken), 32'd0);
        chk_en = 1;
        tick(); idle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cc_we           = ($urandom_range(0, 99) < 30);
            cc_wsel         = CC_SEL_W'($urandom_range(0, NUM_CC - 1));
            cc_in           = 4'($urandom);
            id_branch_instr = ($urandom_range(0, 99) < 70);
            id_pc           = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 5)) << 2);
            id_cond         = 4'($urandom);
            id_annul        = 1'($urandom);
            id_cc_sel       = CC_SEL_W'($urandom_range(0, NUM_CC - 1));
            stall           = ($urandom_range(0, 99) < 15);
            flush           = ($urandom_range(0, 99) < 7);
            tick();
        end
        idle();
        tick();
        chk_en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
